uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity. It is the receive-side counterpart of the team's UART transmitter and uses the same Clk/BAUD timing parameter, so a transmitter and receiver built with equal `Full` interoperate. Each good frame is delivered as a byte with a one-cycle `Valid` strobe. Line glitches are rejected, and a bad stop bit is flagged instead of delivering a byte.

## Interface
- `N`, 5: width of the bit-period counter.
- `Full`, 5'd29: Clk/BAUD − 1. One bit period is `Full`+1 clocks.
- `Half`, 5'd14: clocks from start-edge detection to the start-bit mid-point sample, nominally `Full`/2.
- `Clk` in 1: single clock. All logic is on its rising edge.
- `Reset` in 1: synchronous, active-high. Registered once internally (`tReset`) before use.
- `Rx` in 1: serial line, asynchronous to `Clk`, idle high.
- `Data` out 8: last correctly received byte. Holds its value until the next good frame.
- `Valid` out 1: one-cycle strobe; `Data` is new in the same cycle.
- `FrameError` out 1: one-cycle strobe when the stop bit samples low.
- `Busy` out 1: high while a frame is in progress or the receiver waits for the line to return idle.

## Operation
- `Rx` passes through a 2-flop synchronizer giving `rx_s`, reset value 1. All decisions use `rx_s` only.
- Reset state: `Data`=0, `Valid`=0, `FrameError`=0, `Busy`=0, `Count`=0, `BitCount`=0, State=Idle. Reset aborts a frame in any state with no strobe.
- `Count` (N bits): when non-zero, it decrements and no state action occurs. State actions happen only on edges where `Count`==0.
- States:
  - Idle: on `rx_s`==0, set `Count`←`Half`, `Busy`←1, go to StartBit.
  - StartBit: if `rx_s`==0, set `Count`←`Full`, `BitCount`←7, go to Receiving. If `rx_s`==1 (glitch), set `Busy`←0 and return to Idle.
  - Receiving: shift register ← {`rx_s`, shift[7:1]}, `Count`←`Full`, `BitCount`←`BitCount`−1 (3-bit, wraps). If `BitCount` was 0, go to StopBit.
  - StopBit:
    - If `rx_s`==1: `Data`←shift, `Valid`←1, `Busy`←0, go to Idle.
    - If `rx_s`==0: `FrameError`←1, `Data` unchanged, go to WaitIdle.
  - WaitIdle: stay until `rx_s`==1 (break or stuck-low line), then `Busy`←0 and go to Idle. No `Count` is used in this state.
- `Valid` and `FrameError` are cleared on every edge on which they are not set. They are never high together.
- The state register is 3 bits. Unused encodings go to Idle.

## Timing
- Let E0 be the edge on which Idle sees `rx_s`==0. This is 2–3 clocks after the physical falling edge on `Rx`.
- Start check at E0+`Half`+1.
- Data bit i (i=0..7) sampled at E0+`Half`+1+(i+1)(`Full`+1).
- Stop sample at E0+`Half`+1+9(`Full`+1).
- With defaults:
  - start check at E0+15;
  - bit0 at E0+45, bit7 at E0+255;
  - stop sample at E0+285;
  - `Valid` (or `FrameError`) high for exactly the one cycle after edge E0+285.
- Back-to-back frames: Idle is re-entered at the stop sample. A start edge arriving half a bit later is detected; no idle gap is needed between frames.
- Sampling at bit centre tolerates roughly ±4% baud mismatch over 10 bits.
- `Busy` rises the cycle after E0. It falls the cycle after the stop sample (good frame), the glitch check, or the exit from WaitIdle.

## Test plan
- Frame 0x55 at 30 clocks/bit → one `Valid` pulse with `Data`=0x55, 285 clocks after E0. `FrameError` stays 0 and `Busy` falls with `Valid`.
- Back-to-back frames 0xA3 then 0x0F, no idle gap → two `Valid` pulses 300 clocks apart carrying 0xA3 then 0x0F.
- `Rx` low glitch of 5 clocks → no `Valid` or `FrameError`. `Busy` is high for 15 clocks then 0, and the state is Idle.
- Frame 0xC6 with the stop bit low, then the line held low for 100 clocks → `FrameError` pulses once, `Data` keeps the previous byte, and `Busy` stays high until `Rx` returns high. A following frame 0x21 is received correctly.
- `Reset` asserted during bit 3 of a frame → one cycle after the registered reset, all outputs are 0 and the state is Idle, with no strobe. The next full frame 0x7E is received correctly.
- Frame 0x96 sent at 31 and at 29 clocks/bit → `Data`=0x96 with `Valid` in both cases.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receiver-facing bundle: serial line in, byte/strobe/status out.
interface uart_rx_if;
  logic       Rx;
  logic [7:0] Data;
  logic       Valid;
  logic       FrameError;
  logic       Busy;

  modport master (output Rx, input Data, Valid, FrameError, Busy);
  modport slave  (input Rx, output Data, Valid, FrameError, Busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a start-edge timer, glitch
// rejection on the start bit, framing-error strobe on a low stop bit.
module uart_rx #(
  parameter int         N    = 5,
  parameter logic [N-1:0] Full = 5'd29,
  parameter logic [N-1:0] Half = 5'd14
) (
  input  logic     Clk,
  input  logic     Reset,
  uart_rx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RECV  = 3'd2,
    STOP  = 3'd3,
    WAIT  = 3'd4
  } state_e;

  logic         t_reset_q;
  logic         sync1_q, sync1_d;
  logic         rx_s_q, rx_s_d;
  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [2:0]   bit_count_q, bit_count_d;
  logic [7:0]   shift_q, shift_d;
  logic [7:0]   data_q, data_d;
  logic         valid_q, valid_d;
  logic         ferr_q, ferr_d;
  logic         busy_q, busy_d;

  // Reset is retimed once so its fan-out starts from a single flop.
  always_ff @(posedge Clk) t_reset_q <= Reset;

  always_ff @(posedge Clk) begin
    if (t_reset_q) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      count_q     <= '0;
      bit_count_q <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      count_q     <= count_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    sync1_d     = bus.Rx;
    rx_s_d      = sync1_q;
    state_d     = state_q;
    count_d     = count_q;
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    busy_d      = busy_q;

    // A running timer blocks every state action until it reaches zero.
    if (count_q != '0) begin
      count_d = count_q - N'(1);
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            count_d = Half;
            busy_d  = 1'b1;
            state_d = START;
          end
        end
        START: begin
          if (!rx_s_q) begin
            count_d     = Full;
            bit_count_d = 3'd7;
            state_d     = RECV;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        RECV: begin
          shift_d     = {rx_s_q, shift_q[7:1]};
          count_d     = Full;
          bit_count_d = bit_count_q - 3'd1;
          if (bit_count_q == 3'd0) state_d = STOP;
        end
        STOP: begin
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT;
          end
        end
        WAIT: begin
          // Break or stuck-low line: hold off until the line idles again.
          if (rx_s_q) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.Data       = data_q;
  assign bus.Valid      = valid_q;
  assign bus.FrameError = ferr_q;
  assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random traffic, all checked
// every cycle against a timing-rule model of the receiver.
module tb_uart_rx;
  localparam int FULL = 29;
  localparam int HALF = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_if bus();

  uart_rx #(.N(5), .Full(5'd29), .Half(5'd14)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: the line seen two edges late; events happen at fixed offsets from
  // the edge that first sees a low line while idle.
  localparam int M_IDLE = 0, M_FRAME = 1, M_WAIT = 2;
  int         m_mode = M_IDLE;
  int         m_e0 = 0;
  int         cyc_m = 0;
  bit         m_h1 = 1'b1, m_h2 = 1'b1, m_tres = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] e_data = 8'h00;
  bit         e_valid = 1'b0, e_ferr = 1'b0, e_busy = 1'b0;

  always @(posedge clk) begin
    bit rs, tres;
    int off, n;
    rs = m_h2;
    tres = m_tres;
    m_tres = rst;
    if (tres) begin
      m_h1 = 1'b1; m_h2 = 1'b1; m_mode = M_IDLE;
      e_data = 8'h00; e_valid = 1'b0; e_ferr = 1'b0; e_busy = 1'b0;
    end else begin
      m_h2 = m_h1;
      m_h1 = bus.Rx;
      e_valid = 1'b0;
      e_ferr = 1'b0;
      case (m_mode)
        M_IDLE: if (!rs) begin m_e0 = cyc_m; m_mode = M_FRAME; e_busy = 1'b1; end
        M_FRAME: begin
          off = cyc_m - m_e0 - (HALF + 1);
          if (off == 0) begin
            if (rs) begin m_mode = M_IDLE; e_busy = 1'b0; end
          end else if (off > 0 && off % (FULL + 1) == 0) begin
            n = off / (FULL + 1);
            if (n <= 8) m_byte[n-1] = rs;
            else if (rs) begin
              e_data = m_byte; e_valid = 1'b1; e_busy = 1'b0; m_mode = M_IDLE;
            end else begin
              e_ferr = 1'b1; m_mode = M_WAIT;
            end
          end
        end
        default: if (rs) begin e_busy = 1'b0; m_mode = M_IDLE; end
      endcase
    end
    cyc_m++;
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (bus.Valid !== e_valid || bus.FrameError !== e_ferr ||
          bus.Busy !== e_busy || bus.Data !== e_data) begin
        miscompares++;
        $display("FAIL cycle cyc=%0d got V=%b FE=%b B=%b D=%h want V=%b FE=%b B=%b D=%h",
                 cyc, bus.Valid, bus.FrameError, bus.Busy, bus.Data,
                 e_valid, e_ferr, e_busy, e_data);
      end
    end
  end

  // Pulse log for the directed literal checks.
  int         vq_cyc[$];
  logic [7:0] vq_dat[$];
  logic       vq_busy[$];
  int         fe_cnt = 0;
  int         busy_cnt = 0;

  always @(negedge clk) begin
    if (bus.Valid === 1'b1) begin
      vq_cyc.push_back(cyc);
      vq_dat.push_back(bus.Data);
      vq_busy.push_back(bus.Busy);
    end
    if (bus.FrameError === 1'b1) fe_cnt++;
    if (bus.Busy === 1'b1) busy_cnt++;
  end

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    vq_cyc.delete(); vq_dat.delete(); vq_busy.delete();
    fe_cnt = 0; busy_cnt = 0;
  endtask

  task automatic hold(bit v, int n);
    bus.Rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(logic [7:0] b, int per, bit stop);
    hold(1'b0, per);
    for (int i = 0; i < 8; i++) hold(b[i], per);
    hold(stop, per);
  endtask

  task automatic expect_one(string nm, logic [7:0] d);
    chk({nm, "_count"}, vq_dat.size(), 1);
    if (vq_dat.size() > 0) chk({nm, "_data"}, int'(vq_dat[vq_dat.size()-1]), int'(d));
  endtask

  initial begin
    int fall, kind, per, g;
    logic [7:0] rb;
    bus.Rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_data", int'(bus.Data), 0);
    chk("rst_valid", int'(bus.Valid), 0);
    chk("rst_ferr", int'(bus.FrameError), 0);
    chk("rst_busy", int'(bus.Busy), 0);
    hold(1'b1, 10);

    // Single frame: Valid 288 clocks after the negedge that drops the line.
    clr(); fall = cyc;
    send(8'h55, 30, 1'b1); hold(1'b1, 40);
    expect_one("f55", 8'h55);
    if (vq_cyc.size() == 1) begin
      chk("f55_latency", vq_cyc[0] - fall, 288);
      chk("f55_busy_at_valid", int'(vq_busy[0]), 0);
    end
    chk("f55_ferr", fe_cnt, 0);

    // Back-to-back, no idle gap.
    clr();
    send(8'hA3, 30, 1'b1); send(8'h0F, 30, 1'b1); hold(1'b1, 40);
    chk("b2b_count", vq_dat.size(), 2);
    if (vq_dat.size() == 2) begin
      chk("b2b_d0", int'(vq_dat[0]), 'hA3);
      chk("b2b_d1", int'(vq_dat[1]), 'h0F);
      chk("b2b_gap", vq_cyc[1] - vq_cyc[0], 300);
    end

    // Short low glitch.
    clr();
    hold(1'b0, 5); hold(1'b1, 40);
    chk("glitch_valid", vq_dat.size(), 0);
    chk("glitch_ferr", fe_cnt, 0);
    chk("glitch_busy", busy_cnt, 15);

    // Bad stop bit then a long break.
    clr();
    send(8'hC6, 30, 1'b0); hold(1'b0, 100); hold(1'b1, 40);
    chk("ferr_count", fe_cnt, 1);
    chk("ferr_valid", vq_dat.size(), 0);
    chk("ferr_data_kept", int'(bus.Data), 'h0F);
    chk("ferr_busy", busy_cnt, 400);
    clr();
    send(8'h21, 30, 1'b1); hold(1'b1, 40);
    expect_one("f21", 8'h21);

    // Reset in the middle of bit 3.
    fork
      send(8'h3C, 30, 1'b1);
      begin
        repeat (135) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_data", int'(bus.Data), 0);
        chk("mid_rst_valid", int'(bus.Valid), 0);
        chk("mid_rst_ferr", int'(bus.FrameError), 0);
        chk("mid_rst_busy", int'(bus.Busy), 0);
      end
    join
    hold(1'b1, 400);
    clr();
    send(8'h7E, 30, 1'b1); hold(1'b1, 40);
    expect_one("f7E", 8'h7E);

    // Baud mismatch both ways.
    clr(); send(8'h96, 31, 1'b1); hold(1'b1, 40);
    expect_one("f96_31", 8'h96);
    clr(); send(8'h96, 29, 1'b1); hold(1'b1, 40);
    expect_one("f96_29", 8'h96);

    // Random traffic; the per-cycle compare does the checking.
    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 9));
      rb = 8'($urandom);
      per = int'($urandom_range(29, 31));
      if (kind <= 5) begin
        send(rb, per, 1'b1);
        hold(1'b1, int'($urandom_range(0, 20)));
      end else if (kind == 6) begin
        send(rb, per, 1'b0);
        hold(1'b0, int'($urandom_range(0, 50)));
        hold(1'b1, 30 + int'($urandom_range(0, 20)));
      end else if (kind <= 8) begin
        hold(1'b0, int'($urandom_range(1, 20)));
        hold(1'b1, 20 + int'($urandom_range(0, 20)));
      end else begin
        g = int'($urandom_range(1, 280));
        fork
          send(rb, 30, 1'b1);
          begin
            repeat (g) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
          end
        join
        hold(1'b1, 320);
      end
    end
    hold(1'b1, 320);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
